// File: rtl/armleocpu_regfile_mp.sv
// armleocpu_regfile_mp: multi-port integer register file with a per-register
// busy scoreboard. Register 0 is hardwired to zero and is never busy.
// Optional feature macro: ARMLEOCPU_REGFILE_BYPASS_EN -- when defined, read
// ports forward same-cycle write data (and write-cleared busy) combinationally.
module armleocpu_regfile_mp #(
  parameter int XLEN        = 32,
  parameter int REGS        = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [READ_PORTS*$clog2(REGS)-1:0]  rs_addr,
  output logic [READ_PORTS*XLEN-1:0]    rs_rdata,
  output logic [READ_PORTS-1:0]         rs_busy,
  input  logic [WRITE_PORTS-1:0]        rd_write,
  input  logic [WRITE_PORTS*$clog2(REGS)-1:0] rd_addr,
  input  logic [WRITE_PORTS*XLEN-1:0]   rd_wdata,
  input  logic                          rd_reserve,
  input  logic [$clog2(REGS)-1:0]       rd_reserve_addr,
  output logic                          reserve_collision
);

  localparam int AW = $clog2(REGS);

  logic [XLEN-1:0] regs_q [REGS];
  logic [XLEN-1:0] regs_d [REGS];
  logic [REGS-1:0] busy_q;
  logic [REGS-1:0] busy_d;
  logic            collision_q;
  logic            collision_d;
  logic            rsv_written;

  // Next-state for storage and scoreboard: writes in port order (highest wins),
  // then the reservation so a new producer overrides a same-cycle write clear.
  always_comb begin
    regs_d      = regs_q;
    busy_d      = busy_q;
    rsv_written = 1'b0;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (rd_write[w] && (rd_addr[w*AW +: AW] != '0)) begin
        regs_d[rd_addr[w*AW +: AW]] = rd_wdata[w*XLEN +: XLEN];
        busy_d[rd_addr[w*AW +: AW]] = 1'b0;
        if (rd_addr[w*AW +: AW] == rd_reserve_addr) begin
          rsv_written = 1'b1;
        end
      end
    end
    collision_d = collision_q;
    if (rd_reserve && (rd_reserve_addr != '0)) begin
      busy_d[rd_reserve_addr] = 1'b1;
      if (busy_q[rd_reserve_addr] && !rsv_written) begin
        collision_d = 1'b1;
      end
    end
    // Register 0 never holds data or busy state.
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers: asynchronous clear of data, busy bits and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      collision_q <= collision_d;
    end
  end

  assign reserve_collision = collision_q;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rdata;
    logic            rbusy;

    assign raddr = rs_addr[p*AW +: AW];

    // Read mux: stored value, optionally overridden by a same-cycle write.
    always_comb begin
      rdata = regs_q[raddr];
      rbusy = busy_q[raddr];
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (rst_n && rd_write[w] && (rd_addr[w*AW +: AW] == raddr)) begin
          rdata = rd_wdata[w*XLEN +: XLEN];
          rbusy = rd_reserve && (rd_reserve_addr == raddr);
        end
      end
`endif
      if (raddr == '0) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign rs_rdata[p*XLEN +: XLEN] = rdata;
    assign rs_busy[p]               = rbusy;
  end

endmodule

// File: tb/tb_armleocpu_regfile_mp.sv
// Directed bench for armleocpu_regfile_mp (2 read ports, 2 write ports).
module tb_armleocpu_regfile_mp;

  localparam int XLEN = 32;
  localparam int REGS = 32;
  localparam int RP   = 2;
  localparam int WP   = 2;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst_n;
  logic [RP*AW-1:0]     rs_addr;
  logic [RP*XLEN-1:0]   rs_rdata;
  logic [RP-1:0]        rs_busy;
  logic [WP-1:0]        rd_write;
  logic [WP*AW-1:0]     rd_addr;
  logic [WP*XLEN-1:0]   rd_wdata;
  logic                 rd_reserve;
  logic [AW-1:0]        rd_reserve_addr;
  logic                 reserve_collision;

  int vectors = 0;
  int miscompares = 0;

  armleocpu_regfile_mp #(
    .XLEN(XLEN), .REGS(REGS), .READ_PORTS(RP), .WRITE_PORTS(WP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rs_rdata(rs_rdata), .rs_busy(rs_busy),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .rd_reserve(rd_reserve), .rd_reserve_addr(rd_reserve_addr),
    .reserve_collision(reserve_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    rd_write        = '0;
    rd_addr         = '0;
    rd_wdata        = '0;
    rd_reserve      = 1'b0;
    rd_reserve_addr = '0;
  endtask

  // Drive at negedge, let the next posedge capture, then sample #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rs_addr = {5'd1, 5'd0};
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rs_rdata !== 64'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h want %h", rs_rdata, 64'h0);
    end
    vectors++;
    if (rs_busy !== 2'b00 || reserve_collision !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got busy %b coll %b want 00 0", rs_busy, reserve_collision);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_x0_x1();
    @(negedge clk);
    rd_write = 2'b11;
    rd_addr  = {5'd1, 5'd0};
    rd_wdata = {32'hFF00FF00, 32'hFF00FF00};
    step();
    @(negedge clk);
    idle_inputs();
    rs_addr = {5'd1, 5'd0};
    #1;
    vectors++;
    if (rs_rdata[31:0] !== 32'h0) begin
      miscompares++; $display("FAIL x0_read: got %h want %h", rs_rdata[31:0], 32'h0);
    end
    vectors++;
    if (rs_rdata[63:32] !== 32'hFF00FF00) begin
      miscompares++; $display("FAIL x1_read: got %h want %h", rs_rdata[63:32], 32'hFF00FF00);
    end
    vectors++;
    if (rs_busy !== 2'b00) begin
      miscompares++; $display("FAIL x0_x1_busy: got %b want 00", rs_busy);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    rd_write = 2'b11;
    rd_addr  = {5'd5, 5'd5};
    rd_wdata = {32'h22222222, 32'h11111111};
    step();
    @(negedge clk);
    idle_inputs();
    rs_addr = {5'd5, 5'd5};
    #1;
    vectors++;
    if (rs_rdata !== {32'h22222222, 32'h22222222}) begin
      miscompares++; $display("FAIL dual_write_x5: got %h want %h", rs_rdata, {32'h22222222, 32'h22222222});
    end
  endtask

  task automatic test_reserve();
    @(negedge clk);
    rd_reserve = 1'b1; rd_reserve_addr = 5'd7;
    rs_addr = {5'd7, 5'd7};
    step();
    vectors++;
    if (rs_busy !== 2'b11) begin
      miscompares++; $display("FAIL reserve_x7_busy: got %b want 11", rs_busy);
    end
    @(negedge clk);
    idle_inputs();
    rd_write = 2'b01; rd_addr = {5'd0, 5'd7}; rd_wdata = {32'h0, 32'hA5A5A5A5};
    step();
    vectors++;
    if (rs_busy !== 2'b00 || rs_rdata[31:0] !== 32'hA5A5A5A5) begin
      miscompares++; $display("FAIL write_x7: got busy %b data %h want 00 a5a5a5a5", rs_busy, rs_rdata[31:0]);
    end
    @(negedge clk);
    idle_inputs();
    rd_reserve = 1'b1; rd_reserve_addr = 5'd0;
    rs_addr = {5'd0, 5'd0};
    step();
    vectors++;
    if (rs_busy !== 2'b00 || reserve_collision !== 1'b0) begin
      miscompares++; $display("FAIL reserve_x0: got busy %b coll %b want 00 0", rs_busy, reserve_collision);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle_inputs();
    rd_reserve = 1'b1; rd_reserve_addr = 5'd3;
    rs_addr = {5'd3, 5'd3};
    step();
    // Reserve and write the busy register in the same cycle: no collision.
    @(negedge clk);
    rd_write = 2'b10; rd_addr = {5'd3, 5'd0}; rd_wdata = {32'h33333333, 32'h0};
    step();
    vectors++;
    if (reserve_collision !== 1'b0 || rs_busy !== 2'b11 || rs_rdata[31:0] !== 32'h33333333) begin
      miscompares++; $display("FAIL rsv_write_x3: got coll %b busy %b data %h want 0 11 33333333",
                              reserve_collision, rs_busy, rs_rdata[31:0]);
    end
    @(negedge clk);
    idle_inputs();
    rd_reserve = 1'b1; rd_reserve_addr = 5'd3;
    step();
    vectors++;
    if (reserve_collision !== 1'b1) begin
      miscompares++; $display("FAIL collision_set: got %b want 1", reserve_collision);
    end
    @(negedge clk);
    idle_inputs();
    rd_write = 2'b01; rd_addr = {5'd0, 5'd3}; rd_wdata = {32'h0, 32'h4};
    step();
    @(negedge clk);
    idle_inputs();
    repeat (2) step();
    vectors++;
    if (reserve_collision !== 1'b1 || rs_busy !== 2'b00) begin
      miscompares++; $display("FAIL collision_sticky: got coll %b busy %b want 1 00", reserve_collision, rs_busy);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs();
    rd_write = 2'b01; rd_addr = {5'd0, 5'd9}; rd_wdata = {32'h0, 32'h12345678};
    step();
    @(negedge clk);
    rd_wdata = {32'h0, 32'hDEADBEEF};
    rs_addr  = {5'd9, 5'd9};
    #1;
    vectors++;
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
    if (rs_rdata !== {32'hDEADBEEF, 32'hDEADBEEF} || rs_busy !== 2'b00) begin
      miscompares++; $display("FAIL bypass_same_cycle: got %h busy %b want deadbeef x2 00", rs_rdata, rs_busy);
    end
`else
    if (rs_rdata !== {32'h12345678, 32'h12345678} || rs_busy !== 2'b00) begin
      miscompares++; $display("FAIL nobypass_same_cycle: got %h busy %b want 12345678 x2 00", rs_rdata, rs_busy);
    end
`endif
    step();
    vectors++;
    if (rs_rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL x9_next_cycle: got %h want deadbeef x2", rs_rdata);
    end
    // Same-cycle write plus reserve of the read register.
    @(negedge clk);
    idle_inputs();
    rd_write = 2'b10; rd_addr = {5'd9, 5'd0}; rd_wdata = {32'hCAFEF00D, 32'h0};
    rd_reserve = 1'b1; rd_reserve_addr = 5'd9;
    #1;
    vectors++;
`ifdef ARMLEOCPU_REGFILE_BYPASS_EN
    if (rs_rdata[31:0] !== 32'hCAFEF00D || rs_busy !== 2'b11) begin
      miscompares++; $display("FAIL bypass_rsv: got %h busy %b want cafef00d 11", rs_rdata[31:0], rs_busy);
    end
`else
    if (rs_rdata[31:0] !== 32'hDEADBEEF || rs_busy !== 2'b00) begin
      miscompares++; $display("FAIL nobypass_rsv: got %h busy %b want deadbeef 00", rs_rdata[31:0], rs_busy);
    end
`endif
    step();
    vectors++;
    if (rs_rdata[31:0] !== 32'hCAFEF00D || rs_busy !== 2'b11) begin
      miscompares++; $display("FAIL rsv_write_x9: got %h busy %b want cafef00d 11", rs_rdata[31:0], rs_busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i += 2) begin
      @(negedge clk);
      idle_inputs();
      rd_write = (i + 1 < 32) ? 2'b11 : 2'b01;
      rd_addr  = {5'(i + 1), 5'(i)};
      rd_wdata = {32'h1000 + 32'(i + 1), 32'h1000 + 32'(i)};
      step();
    end
    @(negedge clk);
    idle_inputs();
    rd_reserve = 1'b1; rd_reserve_addr = 5'd4;
    rs_addr = {5'd31, 5'd4};
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (rs_rdata !== {32'h0000101F, 32'h00001004} || rs_busy !== 2'b01) begin
      miscompares++; $display("FAIL pre_reset_state: got %h busy %b want 0000101f00001004 01", rs_rdata, rs_busy);
    end
    // Assert reset away from any clock edge and check without waiting for one.
    #1;
    rst_n = 1'b0;
    rd_write = 2'b01; rd_addr = {5'd0, 5'd4}; rd_wdata = {32'h0, 32'h77777777};
    #1;
    vectors++;
    if (rs_rdata !== 64'h0 || rs_busy !== 2'b00 || reserve_collision !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got %h busy %b coll %b want 0 00 0", rs_rdata, rs_busy, reserve_collision);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    rs_addr = {5'd1, 5'd4};
    #1;
    vectors++;
    if (rs_rdata !== 64'h0 || rs_busy !== 2'b00) begin
      miscompares++; $display("FAIL post_reset: got %h busy %b want 0 00", rs_rdata, rs_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_x0_x1();
    test_dual_write();
    test_reserve();
    test_collision();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/armleocpu_regfile_mp.md
# armleocpu_regfile_mp

Parametrised successor to the single-write, dual-read integer register file. It adds a configurable number of read ports, write ports, width and depth, plus a per-register busy scoreboard so the pipeline can stall on operands that are not yet written. The block sits between decode (reads, reservations) and writeback (writes) of the ArmleoCPU core. Register 0 is hardwired to zero.

## Interface
- XLEN, 32, data width in bits (≥ 8).
- REGS, 32, number of architectural registers (power of two, 2..64); localparam AW = $clog2(REGS).
- READ_PORTS, 2, number of combinational read ports (1..4).
- WRITE_PORTS, 1, number of write ports (1..2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_addr  in  READ_PORTS*AW  read addresses, port p at [p*AW +: AW].
- rs_rdata  out  READ_PORTS*XLEN  read data, combinational from rs_addr.
- rs_busy  out  READ_PORTS  scoreboard busy bit of the addressed register.
- rd_write  in  WRITE_PORTS  write enables.
- rd_addr  in  WRITE_PORTS*AW  write addresses.
- rd_wdata  in  WRITE_PORTS*XLEN  write data.
- rd_reserve  in  1  mark rd_reserve_addr busy (instruction issued with destination).
- rd_reserve_addr  in  AW  register to reserve.
- reserve_collision  out  1  sticky: reserve issued to an already-busy register.

## Operation
- Storage: REGS-1 registers of XLEN bits (index 1..REGS-1); index 0 reads 0 always, writes to 0 are discarded, register 0 never busy.
- Write: on posedge with rd_write[w]=1 and rd_addr[w]≠0, register takes rd_wdata[w] and its busy bit clears.
- Multiple write ports to same address in same cycle: highest port index wins.
- Read: rs_rdata[p] = register[rs_addr[p]]; rs_busy[p] = busy[rs_addr[p]]; any number of ports may read the same address.
- Reserve: on posedge with rd_reserve=1 and rd_reserve_addr≠0, busy bit sets.
- Reserve and write to same address in same cycle: busy ends 1 (new producer wins); data still updated.
- Reserve to address already busy and not being written that cycle: busy stays 1, reserve_collision sets and stays 1 until reset.
- Reserve to address 0: ignored, no collision.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert expected): all registers 0, all busy bits 0, reserve_collision 0; hence rs_rdata = 0, rs_busy = 0 while in reset.
- Write latency: data visible on rs_rdata the cycle after the write edge (zero-cycle with bypass, see Configuration).
- Reserve latency: rs_busy asserts the cycle after the reserve edge.
- No handshakes: every write/reserve is accepted; no back-pressure.
- Reset mid-operation: pending writes/reserves in that cycle are lost; state returns to reset values immediately.

## Configuration
- ARMLEOCPU_REGFILE_BYPASS_EN defined: read ports forward same-cycle writes combinationally — if rd_write[w]=1 and rd_addr[w]=rs_addr[p]≠0, rs_rdata[p]=rd_wdata[w] (highest w wins) and rs_busy[p]=0 unless rd_reserve targets the same address that cycle (then rs_busy[p]=1).
- Not defined: reads return stored values only; written value visible one cycle later; rs_busy reflects stored busy bit.

## Test plan
- Reset then write 32'hFF00FF00 to x0 and x1; read rs_addr={0,1} next cycle -> rs_rdata {0, 32'hFF00FF00}, rs_busy {0,0}.
- WRITE_PORTS=2: both ports write x5 same cycle with 32'h11111111 (port0) and 32'h22222222 (port1) -> x5 reads 32'h22222222.
- Reserve x7 -> rs_busy=1 next cycle; write x7=32'hA5A5A5A5 -> busy 0 next cycle, data 32'hA5A5A5A5; reserve x0 -> busy stays 0.
- Reserve x3 twice without intervening write -> reserve_collision=1 and held; reserve+write x3 same cycle -> no collision, busy remains 1.
- With ARMLEOCPU_REGFILE_BYPASS_EN: write x9=32'hDEADBEEF while reading x9 on all READ_PORTS -> same-cycle rs_rdata 32'hDEADBEEF, rs_busy 0; without macro -> old value that cycle, new value next cycle.
- Assert rst_n low mid-sequence with x1..x31 written and x4 busy -> all reads 0, all busy 0, reserve_collision 0 immediately, without waiting for clk.
